// File: rtl/pc_alu_datapath.sv
// ---------------------------------------------------------------------------
// pc_alu_datapath
//
// Execution core of the multicycle CPU: 64-bit ALU, ALUOut holding register,
// 4-way next-PC selector and the program counter register with a conditional
// write enable. Operands arrive from the A/B source muxes. The PC drives the
// instruction memory address port.
//
// Ports:
//   clk            rising-edge clock for every register
//   reset          asynchronous, active-low reset
//   src_a          ALU operand A (zero-extended PC or saved register A)
//   src_b          ALU operand B (reg B, 4, sign-extended imm, imm<<2)
//   alu_op         ALU operation select
//   pc_select      next-PC source select
//   pc_write       unconditional PC write
//   pc_write_cond  branch PC write, only taken when alu_zero is set
//   alu_result     combinational ALU result
//   alu_zero       combinational, 1 when alu_result is zero
//   alu_out_reg    ALU result registered on every edge (ALUOut)
//   pc_next        combinational selected next PC
//   pc_address     current PC register value
// ---------------------------------------------------------------------------
module pc_alu_datapath #(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 10,
    parameter int                OP_W       = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 10'd512,
    parameter logic [ADDR_W-1:0] JUMP_ADDR  = 10'd512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [1:0]        pc_select,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic [DATA_W-1:0] alu_out_reg,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_address
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] ALU_AND   = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_OR    = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_XOR   = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_SLL   = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_SRL   = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_SUB   = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_SLT   = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_SRA   = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_SLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_PASSB = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_NOR   = OP_W'(12);

    logic [SH_W-1:0]   shAmt;
    logic              ltSigned;
    logic              ltUnsigned;
    logic [DATA_W-1:0] aluOut_q;
    logic [DATA_W-1:0] aluOut_d;
    logic [ADDR_W-1:0] pcAddr_q;
    logic [ADDR_W-1:0] pcAddr_d;
    logic              pcEn;

    assign shAmt      = src_b[SH_W-1:0];
    assign ltSigned   = $signed(src_a) < $signed(src_b);
    assign ltUnsigned = src_a < src_b;

    // ALU: unused operation codes produce zero so nothing downstream sees X.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND:   alu_result = src_a & src_b;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SLL:   alu_result = src_a << shAmt;
            ALU_SRL:   alu_result = src_a >> shAmt;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_SLT:   alu_result = {{(DATA_W-1){1'b0}}, ltSigned};
            ALU_SRA:   alu_result = $unsigned($signed(src_a) >>> shAmt);
            ALU_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, ltUnsigned};
            ALU_PASSB: alu_result = src_b;
            ALU_NOR:   alu_result = ~(src_a | src_b);
            default:   alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // Next-PC select. Source 01 takes the branch target held in ALUOut from
    // the previous cycle, because this cycle's ALU is busy with the compare.
    always_comb begin
        pc_next = RESET_ADDR;
        case (pc_select)
            2'b00:   pc_next = alu_result[ADDR_W-1:0];
            2'b01:   pc_next = aluOut_q[ADDR_W-1:0];
            2'b10:   pc_next = JUMP_ADDR;
            2'b11:   pc_next = RESET_ADDR;
            default: pc_next = RESET_ADDR;
        endcase
    end

    // A branch only writes the PC when the compare result is zero; an
    // unconditional write overrides the compare outcome.
    assign pcEn     = pc_write | (pc_write_cond & alu_zero);
    assign pcAddr_d = pcEn ? pc_next : pcAddr_q;
    assign aluOut_d = alu_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluOut_q <= '0;
            pcAddr_q <= RESET_ADDR;
        end else begin
            aluOut_q <= aluOut_d;
            pcAddr_q <= pcAddr_d;
        end
    end

    assign alu_out_reg = aluOut_q;
    assign pc_address  = pcAddr_q;

endmodule

// File: tb/tb_pc_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_pc_alu_datapath
//
// Scoreboard bench for pc_alu_datapath. Each stimulus cycle pushes the
// outputs the reference model predicts for that cycle; a monitor pops and
// compares them on the falling edge. Directed cases cover fetch, branch
// taken/not taken, ALU corners, PC mux sources and wrap; a randomized phase
// follows, with an asynchronous reset dropped in mid-run.
// ---------------------------------------------------------------------------
module tb_pc_alu_datapath;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic [9:0]  pcNext;
        logic [63:0] aluOutReg;
        logic [9:0]  pcAddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_select;
    logic        pc_write;
    logic        pc_write_cond;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [63:0] alu_out_reg;
    logic [9:0]  pc_next;
    logic [9:0]  pc_address;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    // Reference model state: what the PC and ALUOut registers should hold.
    logic [9:0]  modelPc;
    logic [63:0] modelAluOut;

    pc_alu_datapath dut (
        .clk           (clk),
        .reset         (reset),
        .src_a         (src_a),
        .src_b         (src_b),
        .alu_op        (alu_op),
        .pc_select     (pc_select),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_out_reg   (alu_out_reg),
        .pc_next       (pc_next),
        .pc_address    (pc_address)
    );

    always #5 clk = ~clk;

    // Behavioural ALU written from the operation table with plain arithmetic.
    function automatic logic [63:0] refAlu(input logic [3:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] msb;
        logic [63:0] ones;
        int          sh;
        msb  = 64'h8000_0000_0000_0000;
        ones = '1;
        sh   = int'(b[5:0]);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << sh;
            4'd5:    return a >> sh;
            4'd6:    return a - b;
            4'd7:    return ((a ^ msb) < (b ^ msb)) ? 64'd1 : 64'd0;
            4'd8:    return (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
            4'd9:    return (a < b) ? 64'd1 : 64'd0;
            4'd10:   return b;
            4'd12:   return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of control/operands just after the rising edge, record
    // the predicted outputs for the monitor, then advance the model as the
    // next rising edge will.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [1:0] sel,
                                 input logic pw, input logic pwc);
        exp_t        e;
        logic [63:0] r;
        logic [9:0]  n;
        @(posedge clk);
        #1;
        alu_op        = op;
        src_a         = a;
        src_b         = b;
        pc_select     = sel;
        pc_write      = pw;
        pc_write_cond = pwc;
        r = refAlu(op, a, b);
        case (sel)
            2'b00:   n = r[9:0];
            2'b01:   n = modelAluOut[9:0];
            default: n = 10'd512;
        endcase
        e.res       = r;
        e.zero      = (r == 64'd0);
        e.pcNext    = n;
        e.aluOutReg = modelAluOut;
        e.pcAddr    = modelPc;
        expQ.push_back(e);
        modelAluOut = r;
        if (pw || (pwc && (r == 64'd0)))
            modelPc = n;
    endtask

    // Asynchronous reset pulse placed between edges, with no record in flight.
    task automatic doReset();
        @(posedge clk);
        #1;
        alu_op        = 4'd2;
        src_a         = 64'd5;
        src_b         = 64'd3;
        pc_select     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_pc", 64'(pc_address), 64'd512);
        checkOutput("reset_alu_out_reg", alu_out_reg, 64'd0);
        checkOutput("reset_comb_alu_result", alu_result, 64'd8);
        #2 reset = 1'b1;
        modelPc     = 10'd512;
        modelAluOut = refAlu(alu_op, src_a, src_b);
    endtask

    // Monitor: compares one scoreboard record per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("alu_result", alu_result, e.res);
                checkOutput("alu_zero", 64'(alu_zero), 64'(e.zero));
                checkOutput("pc_next", 64'(pc_next), 64'(e.pcNext));
                checkOutput("alu_out_reg", alu_out_reg, e.aluOutReg);
                checkOutput("pc_address", 64'(pc_address), 64'(e.pcAddr));
            end
        end
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        int          waitCycles;

        reset         = 1'b0;
        alu_op        = 4'd2;
        src_a         = 64'd1;
        src_b         = 64'd1;
        pc_select     = 2'b00;
        pc_write      = 1'b1;
        pc_write_cond = 1'b0;
        modelPc       = 10'd512;
        modelAluOut   = 64'd0;

        // Registers hold their reset values across edges while reset is low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_reset_pc", 64'(pc_address), 64'd512);
        checkOutput("held_reset_alu_out_reg", alu_out_reg, 64'd0);
        doReset();

        // Fetch, then hold with pc_write low.
        applyStimulus(4'd2, 64'd512, 64'd4, 2'b00, 1'b1, 1'b0);
        applyStimulus(4'd2, 64'd512, 64'd4, 2'b00, 1'b0, 1'b0);

        // Branch taken: target into ALUOut, then SUB compare equal.
        applyStimulus(4'd2, 64'd516, 64'h20, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd6, 64'd7, 64'd7, 2'b01, 1'b0, 1'b1);
        // Branch not taken.
        applyStimulus(4'd2, 64'd548, 64'h20, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd6, 64'd7, 64'd3, 2'b01, 1'b0, 1'b1);

        // ALU corners.
        applyStimulus(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd8, 64'h8000_0000_0000_0000, 64'd4, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd5, 64'h8000_0000_0000_0000, 64'd4, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd4, 64'h0000_0000_0000_0003, 64'd62, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd12, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd15, 64'h1234, 64'h5678, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd11, 64'h1234, 64'h5678, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd10, 64'h1234, 64'h5678, 2'b00, 1'b0, 1'b0);

        // PC mux sources and wrap.
        applyStimulus(4'd2, 64'd8, 64'd4, 2'b00, 1'b1, 1'b0);
        applyStimulus(4'd2, 64'd8, 64'd4, 2'b10, 1'b1, 1'b0);
        applyStimulus(4'd2, 64'd8, 64'd4, 2'b00, 1'b1, 1'b0);
        applyStimulus(4'd2, 64'd8, 64'd4, 2'b11, 1'b1, 1'b0);
        applyStimulus(4'd2, 64'd1020, 64'd4, 2'b00, 1'b1, 1'b0);

        // Unconditional write dominates a failed compare.
        applyStimulus(4'd2, 64'd100, 64'd200, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd6, 64'd7, 64'd3, 2'b01, 1'b1, 1'b1);
        applyStimulus(4'd0, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            if (i == 200)
                doReset();
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: begin a = 64'($urandom_range(0, 1023)); b = 64'd4; end
                1: b = a;
                2: b = 64'($urandom_range(0, 63));
                default: ;
            endcase
            applyStimulus(4'($urandom_range(0, 15)), a, b,
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_alu_datapath.md
Name: pc_alu_datapath

Overview:
Execution core of the multicycle CPU. It combines the 64-bit ALU, the ALU output holding register, the 4-way next-PC selector and the 10-bit program counter register with conditional write enable. It sits between the ALU source muxes (A/B select) and the instruction memory address port. Control inputs come from the control FSM.

Parameters:
DATA_W, 64, ALU operand/result width
ADDR_W, 10, PC / instruction address width
OP_W, 4, ALU operation code width
RESET_ADDR, 10'd512, PC value after reset and PC mux source 3 (0x200, first instruction)
JUMP_ADDR, 10'd512, PC mux source 2 (fixed jump target)

Ports:
clk  in  1  system clock, all registers update on rising edge
reset  in  1  asynchronous, active-low reset
src_a  in  DATA_W  ALU operand A (PC zero-extended or saved register A)
src_b  in  DATA_W  ALU operand B (reg B, 4, sign-extended imm, imm<<2)
alu_op  in  OP_W  ALU operation select
pc_select  in  2  next-PC source select
pc_write  in  1  unconditional PC write
pc_write_cond  in  1  branch PC write, qualified by alu_zero
alu_result  out  DATA_W  combinational ALU result
alu_zero  out  1  combinational, 1 when alu_result == 0
alu_out_reg  out  DATA_W  registered ALU result (ALUOut)
pc_next  out  ADDR_W  combinational selected next PC
pc_address  out  ADDR_W  current PC register value

Behaviour:
- Reset (reset==0, asynchronous): pc_address = RESET_ADDR; alu_out_reg = 0. Both hold while reset is low. Combinational outputs follow the inputs regardless of reset.
- ALU, combinational, zero latency. Arithmetic is modulo 2^64 with no carry or overflow outputs. Shift amount = src_b[5:0].
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL (src_a << sh)
  - 0101 SRL (logical)
  - 0110 SUB (src_a - src_b)
  - 0111 SLT (signed, result 64'd1 or 64'd0)
  - 1000 SRA (arithmetic)
  - 1001 SLTU (unsigned)
  - 1010 PASS_B (result = src_b)
  - 1100 NOR
  - all other codes: result = 0 (zero flag then reads 1)
- alu_zero = (alu_result == 0). It is derived from the combinational result, not from the register.
- alu_out_reg loads alu_result on every rising clk edge. There is no enable.
- pc_next mux:
  - 00: alu_result[ADDR_W-1:0] (PC+4 computed this cycle)
  - 01: alu_out_reg[ADDR_W-1:0] (branch target computed the previous cycle)
  - 10: JUMP_ADDR
  - 11: RESET_ADDR
  - Upper bits of 64-bit values are discarded; no range check.
- PC write enable pc_en = pc_write | (pc_write_cond & alu_zero). On a rising edge with pc_en=1, pc_address <= pc_next; otherwise it holds.
- Simultaneous events:
  - pc_write=1 dominates; the cond term is irrelevant.
  - With pc_write_cond=1 and alu_zero=0, the PC holds.
  - Branch timing: the SUB compare and the mux select 01 happen in the same cycle. The PC receives the previous cycle's alu_out_reg, while alu_out_reg is overwritten by the SUB result at that same edge.
- PC wrap: 10-bit truncation; 1020+4 becomes 0.
- Reset asserted mid-operation: PC and alu_out_reg are forced immediately, without waiting for an edge. The first edge after reset rises behaves normally.
- No X propagation on unused op codes. All case statements have defaults.

Test Plan:
1. Assert reset=0 asynchronously between edges -> pc_address=512 and alu_out_reg=0 immediately. Release -> both remain until the next enabled write.
2. Fetch: src_a=512, src_b=4, alu_op=ADD, pc_select=00, pc_write=1, one edge -> pc_address=516 and alu_out_reg=516. Repeat with pc_write=0 -> PC holds 516.
3. Branch taken:
   - Cycle 1: ADD 516+0x20, pc_write=0 -> alu_out_reg=548.
   - Cycle 2: SUB 7-7, alu_zero=1, pc_write_cond=1, pc_select=01 -> pc_address=548.
   Branch not taken: same sequence with SUB 7-3 -> PC unchanged.
4. ALU corners:
   - ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> result 0, zero=1.
   - SLT -1,1 -> 1; SLTU -1,1 -> 0.
   - SRA 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000.
   - SRL by 4 -> 0x0800_0000_0000_0000.
   - NOR 0,0 -> all ones.
   - Undefined op 1111 -> 0.
5. pc_select=10 with pc_write=1 -> PC=512. pc_select=11 -> PC=512. ADD 1020+4 with select 00 -> PC=0 (wrap).
6. pc_write=1 and pc_write_cond=1 with alu_zero=0 -> PC is written with pc_next.
